// File: rtl/bp_nexus_msg_serializer_pkg.sv
// Shared types and constants for the Nexus message serializer.
package bp_nexus_msg_serializer_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned MCODE_W = 6;
  localparam int unsigned NB      = ADDR_W / 8;
  localparam int unsigned NB_W    = $clog2(NB + 1);
  localparam int unsigned IDX_W   = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] MSEO_NORMAL = 2'b00;
  localparam logic [1:0] MSEO_EOF    = 2'b01;
  localparam logic [1:0] MSEO_EOM    = 2'b11;

  typedef struct packed {
    logic [MCODE_W-1:0] mcode;
    logic [ADDR_W-1:0]  addr;
  } nexus_trace_pkt_s;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TCODE = 2'd1,
    ADDR  = 2'd2
  } nexus_ser_state_e;

endpackage

// File: rtl/bp_nexus_addr_compress.sv
// XOR-compresses an address against the previous one and sizes the payload in bytes.
module bp_nexus_addr_compress
  import bp_nexus_msg_serializer_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              full,
  output logic [ADDR_W-1:0] payload,
  output logic [NB_W-1:0]   nbytes
);

  logic [ADDR_W-1:0] delta;

  assign delta   = addr ^ last_addr;
  assign payload = full ? addr : delta;

  // Highest nonzero byte sets the length; an all-zero delta still sends one byte.
  always_comb begin
    nbytes = NB_W'(1);
    for (int i = 1; i < int'(NB); i++) begin
      if (delta[8*i +: 8] != 8'h00) nbytes = NB_W'(i + 1);
    end
    if (full) nbytes = NB_W'(NB);
  end

endmodule

// File: rtl/bp_nexus_msg_serializer.sv
// Serializes trace packets into byte-wide MDO/MSEO beats with XOR address compression
// and a periodic full-address sync message.
module bp_nexus_msg_serializer
  import bp_nexus_msg_serializer_pkg::*;
#(
  parameter int unsigned SYNC_PERIOD = 256
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  nexus_trace_pkt_s trace_pkt_i,
  input  logic             trace_valid_i,
  output logic             trace_ready_o,
  output logic [7:0]       mdo_o,
  output logic [1:0]       mseo_o,
  output logic             mdo_valid_o,
  input  logic             mdo_ready_i,
  output logic             sync_o
);

  localparam int unsigned SC_W = $clog2(SYNC_PERIOD);

  nexus_ser_state_e        state_q;
  logic [NB-1:0][7:0]      payload_q;
  logic [NB_W-1:0]         nbytes_q;
  logic [IDX_W-1:0]        idx_q;
  logic [ADDR_W-1:0]       last_addr_q;
  logic [SC_W-1:0]         sync_cnt_q;
  logic                    first_msg_q;

  logic                    full;
  logic [ADDR_W-1:0]       payload;
  logic [NB_W-1:0]         nbytes;
  logic                    last_byte;
  logic                    beat_acc;
  logic                    pkt_acc;
  logic [IDX_W-1:0]        idx_nxt;

  assign full      = first_msg_q || (sync_cnt_q == SC_W'(SYNC_PERIOD - 1));
  assign last_byte = (NB_W'(idx_q) == nbytes_q - NB_W'(1));
  assign beat_acc  = mdo_valid_o && mdo_ready_i;
  // Ready during the final beat lets the next message start with no bubble.
  assign trace_ready_o = (state_q == IDLE) || (state_q == ADDR && last_byte && mdo_ready_i);
  assign pkt_acc   = trace_valid_i && trace_ready_o;
  assign idx_nxt   = idx_q + IDX_W'(1);

  bp_nexus_addr_compress u_compress (
    .addr      (trace_pkt_i.addr),
    .last_addr (last_addr_q),
    .full      (full),
    .payload   (payload),
    .nbytes    (nbytes)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      payload_q   <= '0;
      nbytes_q    <= '0;
      idx_q       <= '0;
      last_addr_q <= '0;
      sync_cnt_q  <= '0;
      first_msg_q <= 1'b1;
      mdo_o       <= 8'h00;
      mseo_o      <= MSEO_NORMAL;
      mdo_valid_o <= 1'b0;
      sync_o      <= 1'b0;
    end else begin
      case (state_q)
        TCODE: begin
          if (beat_acc) begin
            state_q <= ADDR;
            idx_q   <= '0;
            mdo_o   <= payload_q[0];
            mseo_o  <= (nbytes_q == NB_W'(1)) ? MSEO_EOM : MSEO_NORMAL;
          end
        end
        ADDR: begin
          if (beat_acc && !last_byte) begin
            idx_q  <= idx_nxt;
            mdo_o  <= payload_q[idx_nxt];
            mseo_o <= (NB_W'(idx_nxt) == nbytes_q - NB_W'(1)) ? MSEO_EOM : MSEO_NORMAL;
          end else if (beat_acc) begin
            state_q     <= IDLE;
            mdo_o       <= 8'h00;
            mseo_o      <= MSEO_NORMAL;
            mdo_valid_o <= 1'b0;
            sync_o      <= 1'b0;
          end
        end
        default: ;
      endcase

      // A newly accepted packet overrides the return to IDLE above.
      if (pkt_acc) begin
        state_q     <= TCODE;
        payload_q   <= payload;
        nbytes_q    <= nbytes;
        last_addr_q <= trace_pkt_i.addr;
        sync_cnt_q  <= full ? '0 : sync_cnt_q + SC_W'(1);
        if (full) first_msg_q <= 1'b0;
        mdo_o       <= {2'b00, trace_pkt_i.mcode};
        mseo_o      <= MSEO_EOF;
        mdo_valid_o <= 1'b1;
        sync_o      <= full;
      end
    end
  end

endmodule

// File: tb/tb_bp_nexus_msg_serializer.sv
// Bench for bp_nexus_msg_serializer: directed scenarios plus random traffic checked
// against a message-level reference model.
module tb_bp_nexus_msg_serializer;
  import bp_nexus_msg_serializer_pkg::*;

  localparam int unsigned SP = 4;

  logic             clk_i;
  logic             reset_n_i;
  nexus_trace_pkt_s trace_pkt_i;
  logic             trace_valid_i;
  logic             trace_ready_o;
  logic [7:0]       mdo_o;
  logic [1:0]       mseo_o;
  logic             mdo_valid_o;
  logic             mdo_ready_i;
  logic             sync_o;

  bp_nexus_msg_serializer #(.SYNC_PERIOD(SP)) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .trace_pkt_i   (trace_pkt_i),
    .trace_valid_i (trace_valid_i),
    .trace_ready_o (trace_ready_o),
    .mdo_o         (mdo_o),
    .mseo_o        (mseo_o),
    .mdo_valid_o   (mdo_valid_o),
    .mdo_ready_i   (mdo_ready_i),
    .sync_o        (sync_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] mdo;
    logic [1:0] mseo;
    logic       sync;
  } beat_t;

  beat_t            expq[$];
  nexus_trace_pkt_s pend[$];
  int               checks;
  int               failures;
  int               msg_k;
  logic [31:0]      prev_addr;
  bit               prev_stall;
  beat_t            prev_beat;
  bit               prev_eom_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Message-level model: message k (from reset) is full when k is a multiple of SP.
  function automatic void model_accept(input nexus_trace_pkt_s p);
    bit          full;
    logic [31:0] pl;
    logic [31:0] tmp;
    int          n;
    beat_t       b;
    full = (msg_k % int'(SP)) == 0;
    pl   = full ? p.addr : (p.addr ^ prev_addr);
    n    = 1;
    tmp  = pl >> 8;
    while (tmp != 0) begin
      n++;
      tmp = tmp >> 8;
    end
    if (full) n = 4;
    b.mdo = {2'b00, p.mcode}; b.mseo = 2'b01; b.sync = full;
    expq.push_back(b);
    for (int i = 0; i < n; i++) begin
      b.mdo  = 8'((pl >> (8 * i)) & 32'hFF);
      b.mseo = (i == n - 1) ? 2'b11 : 2'b00;
      b.sync = full;
      expq.push_back(b);
    end
    prev_addr = p.addr;
    msg_k++;
  endfunction

  function automatic void model_reset();
    msg_k        = 0;
    prev_addr    = '0;
    prev_stall   = 1'b0;
    prev_eom_acc = 1'b0;
    expq.delete();
    pend.delete();
  endfunction

  // One clock: drive inputs, check outputs, update the model, advance to the next edge.
  task automatic run_cycle(input bit rdy, input bit offer);
    beat_t b;
    bit    xfer;
    bit    acc;
    #1;
    mdo_ready_i = rdy;
    if (offer && pend.size() > 0) begin
      trace_valid_i = 1'b1;
      trace_pkt_i   = pend[0];
    end else begin
      trace_valid_i = 1'b0;
    end
    #1;
    if (prev_stall) begin
      check("stall_valid", 32'(mdo_valid_o), 32'd1);
      check("stall_mdo",   32'(mdo_o),  32'(prev_beat.mdo));
      check("stall_mseo",  32'(mseo_o), 32'(prev_beat.mseo));
      check("stall_sync",  32'(sync_o), 32'(prev_beat.sync));
    end
    if (prev_eom_acc) check("no_bubble", 32'(mdo_valid_o), 32'd1);
    xfer = mdo_valid_o && rdy;
    if (xfer) begin
      if (expq.size() == 0) begin
        check("extra_beat", 32'(mdo_o), 32'hFFFF_FFFF);
      end else begin
        b = expq.pop_front();
        check("mdo",  32'(mdo_o),  32'(b.mdo));
        check("mseo", 32'(mseo_o), 32'(b.mseo));
        check("sync", 32'(sync_o), 32'(b.sync));
      end
    end
    check("trace_ready", 32'(trace_ready_o), 32'(expq.size() == 0));
    acc = trace_valid_i && trace_ready_o;
    if (acc) model_accept(pend.pop_front());
    prev_stall     = mdo_valid_o && !rdy;
    prev_beat.mdo  = mdo_o;
    prev_beat.mseo = mseo_o;
    prev_beat.sync = sync_o;
    prev_eom_acc   = xfer && (mseo_o == 2'b11) && acc;
    @(posedge clk_i);
  endtask

  task automatic drain(input int rdy_pct, input int offer_pct);
    int cyc;
    cyc = 0;
    while ((pend.size() > 0 || expq.size() > 0) && cyc < 2000) begin
      run_cycle($urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < offer_pct);
      cyc++;
    end
    check("drain_left", 32'(pend.size() + expq.size()), 32'd0);
    run_cycle(1'b1, 1'b0);
    check("idle_valid", 32'(mdo_valid_o), 32'd0);
  endtask

  function automatic nexus_trace_pkt_s mk(input logic [5:0] mc, input logic [31:0] a);
    nexus_trace_pkt_s p;
    p.mcode = mc;
    p.addr  = a;
    return p;
  endfunction

  initial begin
    logic [31:0] a;
    checks        = 0;
    failures      = 0;
    reset_n_i     = 1'b0;
    trace_valid_i = 1'b0;
    trace_pkt_i   = '0;
    mdo_ready_i   = 1'b0;
    model_reset();

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_mdo",   32'(mdo_o),         32'd0);
    check("rst_mseo",  32'(mseo_o),        32'd0);
    check("rst_valid", 32'(mdo_valid_o),   32'd0);
    check("rst_sync",  32'(sync_o),        32'd0);
    check("rst_ready", 32'(trace_ready_o), 32'd1);
    #2 reset_n_i = 1'b1;
    @(posedge clk_i);

    // Full first message, then a compressed delta, then a zero delta.
    pend.push_back(mk(6'h03, 32'h0000_1000));
    pend.push_back(mk(6'h03, 32'h0000_2000));
    pend.push_back(mk(6'h03, 32'h0000_2000));
    drain(100, 100);

    // Sink stall mid-message.
    pend.push_back(mk(6'h05, 32'h1234_5678));
    run_cycle(1'b1, 1'b1);
    run_cycle(1'b1, 1'b1);
    repeat (3) run_cycle(1'b0, 1'b1);
    drain(100, 100);

    // Back-to-back messages.
    pend.push_back(mk(6'h07, 32'h1234_5600));
    pend.push_back(mk(6'h08, 32'h1234_5700));
    drain(100, 100);

    // Reset during an ADDR beat.
    pend.push_back(mk(6'h09, 32'hDEAD_BEEF));
    run_cycle(1'b1, 1'b1);
    run_cycle(1'b1, 1'b1);
    #1 reset_n_i = 1'b0;
    trace_valid_i = 1'b0;
    #1;
    check("arst_valid", 32'(mdo_valid_o),   32'd0);
    check("arst_sync",  32'(sync_o),        32'd0);
    check("arst_ready", 32'(trace_ready_o), 32'd1);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 check("arst_hold_valid", 32'(mdo_valid_o), 32'd0);
    #2 reset_n_i = 1'b1;
    @(posedge clk_i);

    // Five small-delta messages after reset: the 1st and 5th are full.
    a = 32'h8000_0100;
    for (int i = 0; i < 5; i++) begin
      pend.push_back(mk(6'h03, a));
      a = a + 32'(i * 4 + 4);
    end
    drain(100, 100);

    // Random traffic with random backpressure and valid gaps.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) a = $urandom();
      else a = a ^ 32'($urandom_range(0, 255) << (8 * $urandom_range(0, 3)));
      pend.push_back(mk(6'($urandom_range(0, 63)), a));
    end
    drain(70, 70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
